// File: rtl/avmm_onchip_ram_pipelined.sv
// rtl/avmm_onchip_ram_pipelined.sv - Avalon-MM single-port on-chip RAM with pipelined reads
// Byte-lane writes, optional post-reset zero sweep, 1 or 2 cycle read latency, global clken stall.
module avmm_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 10000,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_ok_q, s1_ok_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
  logic [DATA_WIDTH-1:0]   ram_rd_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range, accept, wr_acc, rd_acc, clearing, mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   mem_wdata, s1_word;
  logic [NB-1:0]           mem_be;

  assign waitrequest = ~clken | (state_q != S_READY) | ~reset_n;

  always_comb begin
    in_range  = ({1'b0, address} < DEPTH_W);
    accept    = chipselect & (read | write) & ~waitrequest;
    wr_acc    = accept & write;
    rd_acc    = accept & read & ~write;
    clearing  = (state_q == S_CLEAR) & clken & reset_n;
    mem_we    = clearing | (wr_acc & in_range);
    mem_idx   = clearing ? cnt_q[IDX_W-1:0] : address[IDX_W-1:0];
    mem_wdata = clearing ? '0 : writedata;
    mem_be    = clearing ? '1 : byteenable;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (clearing) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_W) state_d = S_READY;
    end

    // Out-of-range reads travel through the pipe as a zero-data response.
    s1_word    = s1_ok_q ? ram_rd_q : '0;
    s1_valid_d = clken ? rd_acc : s1_valid_q;
    s1_ok_d    = rd_acc ? in_range : s1_ok_q;
    s2_valid_d = clken ? s1_valid_q : s2_valid_q;
    s2_data_d  = (clken & s1_valid_q) ? s1_word : s2_data_q;

    if (READ_LATENCY == 2) begin
      readdata      = s2_data_q;
      readdatavalid = clken & s2_valid_q;
    end else begin
      readdata      = s1_word;
      readdatavalid = clken & s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_ok_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_ok_q    <= s1_ok_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // Storage kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    if (rd_acc) ram_rd_q <= mem[address[IDX_W-1:0]];
  end
endmodule

// File: tb/tb_avmm_onchip_ram_pipelined.sv
// tb/tb_avmm_onchip_ram_pipelined.sv - directed self-checking bench for avmm_onchip_ram_pipelined
module tb_avmm_onchip_ram_pipelined;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, chipselect, read, write, clken;
  logic [4:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rd2, rd1;
  logic        v2, v1, w2, w1;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int n0, nw2, nw1;
  logic [31:0] q2d[$], q1d[$];
  int          q2c[$], q1c[$];

  avmm_onchip_ram_pipelined #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd2), .readdatavalid(v2), .waitrequest(w2));

  avmm_onchip_ram_pipelined #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd1), .readdatavalid(v1), .waitrequest(w1));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v2) begin q2d.push_back(rd2); q2c.push_back(cyc); end
    if (v1) begin q1d.push_back(rd1); q1c.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cs, input logic rq, input logic wq, input logic [4:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    chipselect = cs; read = rq; write = wq; address = a; byteenable = be; writedata = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, be, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic flush;
    q2d.delete(); q1d.delete(); q2c.delete(); q1c.delete();
  endtask

  task automatic count_wait(output int c2, output int c1);
    c2 = 0; c1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (w2) c2++;
      if (w1) c1++;
      if (!w2 && !w1) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_waitrequest", {31'b0, w2}, 32'd1);
    check("reset_rdv", {30'b0, v2, v1}, 32'd0);
    check("reset_readdata_l2", rd2, 32'h0);
    check("reset_readdata_l1", rd1, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    count_wait(nw2, nw1);
    check("clear_wait_cycles_l2", nw2, 32'd16);
    check("clear_wait_cycles_l1", nw1, 32'd16);

    flush();
    for (int a = 0; a < 16; a++) rd(a[4:0]);
    idle(5);
    check("clear_resp_count", q2d.size(), 32'd16);
    check("clear_resp_span", q2c[15] - q2c[0], 32'd15);
    for (int a = 0; a < 16; a++) check($sformatf("clear_word_%0d", a), q2d[a] | q1d[a], 32'h0);

    wr(5'd5, 4'hF, 32'hAABBCCDD);
    wr(5'd5, 4'h5, 32'h11223344);
    flush();
    n0 = cyc;
    rd(5'd5);
    idle(4);
    check("be_data_l2", q2d[0], 32'hAA22CC44);
    check("be_latency_l2", q2c[0] - n0, 32'd2);
    check("be_data_l1", q1d[0], 32'hAA22CC44);
    check("be_latency_l1", q1c[0] - n0, 32'd1);

    for (int a = 0; a < 8; a++) wr(a[4:0], 4'hF, 32'(3 * a));
    flush();
    for (int a = 0; a < 8; a++) rd(a[4:0]);
    idle(5);
    check("b2b_count", q2d.size(), 32'd8);
    check("b2b_span", q2c[7] - q2c[0], 32'd7);
    check("b2b_count_l1", q1d.size(), 32'd8);
    for (int a = 0; a < 8; a++) check($sformatf("b2b_data_%0d", a), q2d[a], 32'(3 * a));
    check("b2b_data_l1_7", q1d[7], 32'd21);

    flush();
    wr(5'd9, 4'hF, 32'h5A5A5A5A);
    rd(5'd9);
    idle(4);
    check("raw_l2", q2d[0], 32'h5A5A5A5A);
    check("raw_l1", q1d[0], 32'h5A5A5A5A);

    wr(5'd0, 4'hF, 32'h12345678);
    wr(5'd16, 4'hF, 32'hFFFFFFFF);
    flush();
    rd(5'd16);
    rd(5'd0);
    idle(4);
    check("oor_count", q2d.size(), 32'd2);
    check("oor_read_zero", q2d[0], 32'h0);
    check("oor_addr0_kept", q2d[1], 32'h12345678);
    check("oor_read_zero_l1", q1d[0], 32'h0);
    @(negedge clk);
    check("readdata_hold", rd2, 32'h12345678);
    @(posedge clk); #1;

    flush();
    n0 = cyc;
    rd(5'd9);
    clken = 1'b0;
    @(negedge clk);
    check("stall_waitrequest", {31'b0, w2}, 32'd1);
    check("stall_rdv_forced_low", {30'b0, v2, v1}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clken = 1'b1;
    idle(4);
    check("stall_latency_l2", q2c[0] - n0, 32'd5);
    check("stall_data_l2", q2d[0], 32'h5A5A5A5A);
    check("stall_latency_l1", q1c[0] - n0, 32'd4);
    check("stall_count_l2", q2d.size(), 32'd1);

    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    count_wait(nw2, nw1);
    check("reclear_wait_cycles", nw2, 32'd16);
    flush();
    rd(5'd0);
    rd(5'd7);
    rd(5'd9);
    idle(5);
    check("reclear_count", q2d.size(), 32'd3);
    check("reclear_word0", q2d[0], 32'h0);
    check("reclear_word7", q2d[1], 32'h0);
    check("reclear_word9", q2d[2], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
